// File: rtl/palette_access_ctrl_pkg.sv
// palette_access_ctrl_pkg: access FSM states, palette bank codes and the posted-write entry type
package palette_access_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, RELEASE} pal_state_t;
  localparam logic [1:0] BANK_R = 2'd0;
  localparam logic [1:0] BANK_R_ALT = 2'd3;
  localparam logic [1:0] BANK_G = 2'd1;
  localparam logic [1:0] BANK_B = 2'd2;
  typedef struct packed {
    logic [10:0] addr;
    logic [4:0]  data;
  } wr_entry_t;
endpackage

// File: rtl/palette_access_ctrl_if.sv
// palette_access_ctrl_if: CPU request/acknowledge bus into the palette access controller
interface palette_access_ctrl_if;
  logic        CPU_REQ;
  logic        CPU_WR;
  logic [10:0] CPU_ADDR;
  logic [15:0] CPU_DIN;
  logic        CPU_ACK;
  logic [15:0] CPU_DOUT;
  modport master (output CPU_REQ, CPU_WR, CPU_ADDR, CPU_DIN, input CPU_ACK, CPU_DOUT);
  modport slave (input CPU_REQ, CPU_WR, CPU_ADDR, CPU_DIN, output CPU_ACK, CPU_DOUT);
endinterface

// File: rtl/palette_access_ctrl_pal_wr_fifo.sv
// pal_wr_fifo: synchronous write-posting FIFO with occupancy level; pointers wrap at DEPTH
module pal_wr_fifo
  import palette_access_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             CLK_32M,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  wr_entry_t        din,
  output wr_entry_t        dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  wr_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = level == LVL_W'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge CLK_32M) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end
endmodule

// File: rtl/palette_access_ctrl.sv
// palette_access_ctrl: posts CPU writes and sequences in-order CPU reads into the palette RAM during blanking.
// Define PALETTE_ACCESS_STEAL_EN to add STEAL_OK, letting a nearly full FIFO drain outside blanking.
module palette_access_ctrl
  import palette_access_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic                 CLK_32M,
  input  logic                 RESET,
  input  logic                 BLANK,
`ifdef PALETTE_ACCESS_STEAL_EN
  input  logic                 STEAL_OK,
`endif
  palette_access_ctrl_if.slave cpu,
  output logic                 PAL_G,
  output logic                 PAL_MWR,
  output logic                 PAL_MRD,
  output logic [10:0]          PAL_A,
  output logic [15:0]          PAL_DIN,
  input  logic [15:0]          PAL_DOUT,
  input  logic                 PAL_DOUT_VALID,
  output logic [LVL_W-1:0]     FIFO_LEVEL,
  output logic                 BUSY
);
  pal_state_t state;
  wr_entry_t  head, wr_entry;
  logic full, empty, op_rd, rd_latched, cpu_ack, wr_take, rd_take, pop, start_ok, unused_din;
  logic [10:0] rd_addr;
  logic [15:0] cpu_dout;
  // the ACK cycle blocks acceptance so a request still held during ACK is not taken twice
  assign wr_take  = cpu.CPU_REQ & cpu.CPU_WR & ~full & ~rd_latched & ~cpu_ack;
  assign rd_take  = cpu.CPU_REQ & ~cpu.CPU_WR & empty & (state == IDLE) & ~rd_latched & ~cpu_ack;
  assign pop      = (state == STROBE) & ~op_rd;
`ifdef PALETTE_ACCESS_STEAL_EN
  assign start_ok = (BLANK & (~empty | rd_latched)) | (STEAL_OK & (FIFO_LEVEL >= LVL_W'(FIFO_DEPTH - 1)));
`else
  assign start_ok = BLANK & (~empty | rd_latched);
`endif
  assign BUSY         = (state != IDLE) | ~empty;
  assign cpu.CPU_ACK  = cpu_ack;
  assign cpu.CPU_DOUT = cpu_dout;
  assign wr_entry     = {cpu.CPU_ADDR, cpu.CPU_DIN[4:0]};
  assign unused_din   = ^cpu.CPU_DIN[15:5];
  pal_wr_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .CLK_32M, .RESET, .push(wr_take), .pop, .din(wr_entry), .dout(head),
    .full, .empty, .level(FIFO_LEVEL)
  );
  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      state      <= IDLE;
      op_rd      <= 1'b0;
      rd_latched <= 1'b0;
      rd_addr    <= '0;
      cpu_ack    <= 1'b0;
      cpu_dout   <= '0;
      PAL_G      <= 1'b0;
      PAL_MWR    <= 1'b0;
      PAL_MRD    <= 1'b0;
      PAL_A      <= '0;
      PAL_DIN    <= '0;
    end else begin
      cpu_ack <= wr_take;
      if (rd_take) begin
        rd_latched <= 1'b1;
        rd_addr    <= cpu.CPU_ADDR;
      end
      case (state)
        SETUP: begin
          state   <= STROBE;
          PAL_MWR <= ~op_rd;
          PAL_MRD <= op_rd;
        end
        STROBE: begin
          state   <= op_rd ? CAPTURE : RELEASE;
          PAL_G   <= op_rd;
          PAL_MWR <= 1'b0;
          PAL_MRD <= op_rd;
        end
        CAPTURE: begin
          state      <= RELEASE;
          PAL_G      <= 1'b0;
          PAL_MRD    <= 1'b0;
          rd_latched <= 1'b0;
          cpu_ack    <= 1'b1;
          if (PAL_DOUT_VALID) cpu_dout <= PAL_DOUT;
        end
        // IDLE and RELEASE: an empty FIFO with a latched read means the read goes next
        default: if (start_ok) begin
          state   <= SETUP;
          PAL_G   <= 1'b1;
          op_rd   <= empty;
          PAL_A   <= empty ? rd_addr : head.addr;
          PAL_DIN <= empty ? 16'd0 : {11'd0, head.data};
        end else begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
